instr_sequencer: RTL and testbench

//  Upstream control stage of the datapath. Holds the 16-bit instruction register (IR), decodes it, and runs
//  a Moore FSM. The FSM drives every datapath control (readnum, writenum, write, loada, loadb, asel, bsel,

---
 rtl/instr_sequencer.sv | 93 +++++++++
 tb/tb_instr_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction register, decoder and Moore control FSM for the datapath (option: ILLEGAL_TRAP_EN)
module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [3:0]  vsel,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);
  typedef enum logic [2:0] {
    WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG
`ifdef ILLEGAL_TRAP_EN
    , HALT
`endif
  } state_t;
  state_t state, nxt;
  logic [15:0] ir;
  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op;
  logic is_movi, is_mov, is_mvn, is_arith, is_cmp;
  assign opc = ir[15:13];
  assign op = ir[12:11];
  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign rm = ir[2:0];
  assign is_movi = opc == 3'b110 && op == 2'b10;
  assign is_mov = opc == 3'b110 && op == 2'b00;
  assign is_mvn = opc == 3'b101 && op == 2'b11;
  assign is_arith = opc == 3'b101 && op != 2'b11;
  assign is_cmp = opc == 3'b101 && op == 2'b01;
  // state register and IR; IR only accepts a new word while idle so an instruction in flight is stable
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT;
      ir <= 16'h0000;
    end else begin
      state <= nxt;
      if (load && state == WAIT) ir <= in;
    end
  end
  // next-state: DECODE sees the word captured on the same edge that left WAIT
  always_comb begin
    nxt = WAIT;
    case (state)
      WAIT:      nxt = s ? DECODE : WAIT;
`ifdef ILLEGAL_TRAP_EN
      DECODE:    nxt = is_movi ? WRITE_IMM : (is_mov || is_mvn) ? GET_B : is_arith ? GET_A : HALT;
      HALT:      nxt = HALT;
`else
      DECODE:    nxt = is_movi ? WRITE_IMM : (is_mov || is_mvn) ? GET_B : is_arith ? GET_A : WAIT;
`endif
      GET_A:     nxt = GET_B;
      GET_B:     nxt = ALU;
      ALU:       nxt = is_cmp ? WAIT : WRITE_REG;
      default:   nxt = WAIT;
    endcase
  end
  assign w = state == WAIT;
`ifdef ILLEGAL_TRAP_EN
  assign illegal = state == HALT;
`else
  assign illegal = 1'b0;
`endif
  assign readnum = state == GET_A ? rn : rm;
  assign writenum = state == WRITE_IMM ? rn : rd;
  assign write = !reset && (state == WRITE_IMM || state == WRITE_REG);
  assign loada = !reset && state == GET_A;
  assign loadb = !reset && state == GET_B;
  assign loadc = !reset && state == ALU && !is_cmp;
  assign loads = !reset && state == ALU && is_cmp;
  assign asel = state == ALU && (is_mov || is_mvn);
  assign bsel = 1'b0;
  assign ALUop = (state == ALU && opc == 3'b101) ? op : 2'b00;
  assign vsel = state == WRITE_IMM ? 4'b0100 : 4'b0001;
  assign shift = ir[4:3];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized scoreboard bench for instr_sequencer (honours ILLEGAL_TRAP_EN)
module tb_instr_sequencer;
  logic clk = 0, rst = 1, load = 0, s = 0;
  logic [15:0] instr = 0;
  logic w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0] readnum, writenum;
  logic [1:0] shift, ALUop;
  logic [3:0] vsel;
  logic [15:0] sximm8, sximm5;
  typedef struct packed {
    logic w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] aluop, shift;
    logic [3:0] vsel;
    logic [2:0] readnum, writenum;
    logic [15:0] sximm8, sximm5;
  } exp_t;
  exp_t q[$];
  logic [15:0] ir_m = 0;
  bit halted;
  int pass_cnt = 0, chk_cnt = 0;
  instr_sequencer dut (
    .clk(clk), .reset(rst), .in(instr), .load(load), .s(s), .w(w), .illegal(illegal),
    .readnum(readnum), .writenum(writenum), .write(write), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .vsel(vsel), .sximm8(sximm8), .sximm5(sximm5)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (ir_model=%h t=%0t)", name, act, exp, ir_m, $time);
  endtask
  // quiet control word for a given IR: every enable low, fields straight from the instruction
  function automatic exp_t base(input logic [15:0] v);
    exp_t r = '0;
    r.shift = v[4:3];
    r.sximm8 = 16'($signed(v[7:0]));
    r.sximm5 = 16'($signed(v[4:0]));
    r.vsel = 4'b0001;
    r.readnum = v[2:0];
    r.writenum = v[7:5];
    return r;
  endfunction
  // expected per-cycle outputs from the cycle after s is sampled until back in WAIT
  function automatic void push_seq(input logic [15:0] v);
    exp_t d = base(v), r;
    logic [2:0] opc = v[15:13];
    logic [1:0] op = v[12:11];
    bit movi = opc == 6 && op == 2, mov = opc == 6 && op == 0, mvn = opc == 5 && op == 3;
    bit cmp = opc == 5 && op == 1, arith = opc == 5 && op != 3;
    halted = 0;
    q.push_back(d);
    if (movi) begin
      r = d; r.write = 1; r.writenum = v[10:8]; r.vsel = 4'b0100; q.push_back(r);
    end else if (mov || mvn || arith) begin
      if (arith) begin
        r = d; r.readnum = v[10:8]; r.loada = 1; q.push_back(r);
      end
      r = d; r.loadb = 1; q.push_back(r);
      r = d; r.asel = mov || mvn; r.aluop = opc == 5 ? op : 2'b00;
      if (cmp) r.loads = 1; else r.loadc = 1;
      q.push_back(r);
      if (!cmp) begin
        r = d; r.write = 1; q.push_back(r);
      end
    end else begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) begin
        r = d; r.illegal = 1; q.push_back(r);
      end
      halted = 1;
      return;
`endif
    end
    r = d; r.w = 1; q.push_back(r);
  endfunction
  // monitor: reset forcing, scheduled steps, or quiet idle
  always @(negedge clk) begin
    exp_t a, e;
    a = '{w, illegal, write, loada, loadb, loadc, loads, asel, bsel, ALUop, shift, vsel,
          readnum, writenum, sximm8, sximm5};
    if (rst) chk("reset_enables", 64'({write, loada, loadb, loadc, loads}), 64'd0);
    else if (q.size() != 0) begin
      e = q.pop_front();
      chk("step", 64'(a), 64'(e));
    end else begin
      e = base(ir_m); e.w = 1;
      chk("idle", 64'(a), 64'(e));
    end
  end
  task automatic pulse_reset();
    rst = 1; q.delete(); ir_m = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask
  task automatic run_instr(input logic [15:0] v, input bit ld, input int abort);
    int n, t;
    s = 1; load = ld; instr = ld ? v : 16'($urandom);
    @(posedge clk); #1;
    s = 0; load = 0;
    if (ld) ir_m = v;
    push_seq(ir_m);
    n = q.size();
    for (int k = 1; k < n; k++) begin
      if (abort == k) begin
        pulse_reset();
        return;
      end
      load = 1'($urandom); instr = 16'($urandom); s = 1'($urandom);
      @(posedge clk); #1;
    end
    load = 0; s = 0;
    if (halted) begin
      @(posedge clk); #1;
      pulse_reset();
      return;
    end
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk); t++;
    end
    if (q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d steps left, expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
    repeat ($urandom_range(0, 2)) begin
      if ($urandom_range(0, 1) == 1) begin
        load = 1; instr = 16'($urandom);
        @(posedge clk); #1;
        load = 0; ir_m = instr;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask
  function automatic logic [15:0] gen();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(0, 6))
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2: r[15:11] = 5'b10111;
      3: r[15:11] = 5'b10100;
      4: r[15:11] = 5'b10101;
      5: r[15:11] = 5'b10110;
      default: ;
    endcase
    return r;
  endfunction
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    run_instr(16'hD0FE, 1, 0);
    run_instr(16'hA148, 1, 0);
    run_instr(16'hA148, 0, 3);
    run_instr(16'hA900, 1, 0);
    run_instr(16'hB840, 1, 0);
    run_instr(16'hC0E1, 1, 0);
    run_instr(16'h0000, 1, 0);
    for (int i = 0; i < 150; i++) run_instr(gen(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0 ? 2 : 0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
